// File: rtl/fft_peak_detect.sv
// Peak search over one frame of squared-modulus words read from a FIFO with one-cycle read latency.
// Reports the strongest non-DC bin, the word count, and whether the frame was cut off at MAX_LEN.
module fft_peak_detect #(
  parameter int SKIP_BINS = 2,
  parameter int MAX_LEN   = 4096  // must fit in the 13-bit frame_len
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        fifo_rd_en,
  input  logic [72:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        peak_valid,
  output logic [11:0] peak_index,
  output logic [59:0] peak_mag,
  output logic [12:0] frame_len,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e      state_q;
  logic        busy_q;
  logic        dv_q;
  logic [59:0] best_mag_q, best_mag_d;
  logic [11:0] best_idx_q, best_idx_d;
  logic [12:0] count_q, count_d;
  logic        peak_valid_q;
  logic [11:0] peak_index_q;
  logic [59:0] peak_mag_q;
  logic [12:0] frame_len_q;
  logic        frame_err_q;

  logic        word_last;
  logic [11:0] word_idx;
  logic [59:0] word_mag;
  logic        eligible;
  logic        hit_max;
  logic        term;

  assign word_last = fifo_rd_data[72];
  assign word_idx  = fifo_rd_data[71:60];
  assign word_mag  = fifo_rd_data[59:0];

  // Strict compare keeps the earliest-arriving bin on ties.
  assign eligible = dv_q && ({20'd0, word_idx} >= 32'(SKIP_BINS)) && (word_mag > best_mag_q);

  always_comb begin
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    count_d    = count_q;
    if (eligible) begin
      best_mag_d = word_mag;
      best_idx_d = word_idx;
    end
    if (dv_q && (count_q != 13'(MAX_LEN))) begin
      count_d = count_q + 13'd1;
    end
  end

  assign hit_max = (count_d == 13'(MAX_LEN));
  assign term    = dv_q && (word_last || hit_max);

  // The terminating word gates its own cycle's read so the next frame stays in the FIFO.
  assign fifo_rd_en = (state_q == READ) && !fifo_empty && !term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      dv_q         <= 1'b0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      count_q      <= '0;
      peak_valid_q <= 1'b0;
      peak_index_q <= '0;
      peak_mag_q   <= '0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      dv_q <= fifo_rd_en;
      case (state_q)
        IDLE: begin
          peak_valid_q <= 1'b0;
          if (start) begin
            best_mag_q <= '0;
            best_idx_q <= '0;
            count_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= READ;
          end
        end
        READ: begin
          best_mag_q <= best_mag_d;
          best_idx_q <= best_idx_d;
          count_q    <= count_d;
          if (term) begin
            state_q      <= DONE;
            peak_valid_q <= 1'b1;
            peak_index_q <= best_idx_d;
            peak_mag_q   <= best_mag_d;
            frame_len_q  <= count_d;
            frame_err_q  <= hit_max && !word_last;
          end
        end
        DONE: begin
          peak_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign peak_valid = peak_valid_q;
  assign peak_index = peak_index_q;
  assign peak_mag   = peak_mag_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect: a one-cycle-latency FIFO model feeds directed and random frames,
// and each result is compared with a frame-walking reference model.
module tb_fft_peak_detect;
  localparam int SKIP = 2;
  localparam int MAXL = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, fifo_rd_en, fifo_empty, peak_valid, frame_err;
  logic [72:0] fifo_rd_data = '0;
  logic [11:0] peak_index;
  logic [59:0] peak_mag;
  logic [12:0] frame_len;

  fft_peak_detect #(.SKIP_BINS(SKIP), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .peak_valid(peak_valid), .peak_index(peak_index), .peak_mag(peak_mag),
    .frame_len(frame_len), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [72:0] mem [0:16383];
  int   wp = 0;
  int   rp = 0;
  logic flush_req = 1'b0;
  logic stall_en = 1'b0;
  logic stall_q = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   pv_cnt = 0;
  int   viol = 0;

  assign fifo_empty = (rp == wp) || stall_q;

  always @(posedge clk) begin
    if (flush_req) rp <= wp;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp];
      rp <= rp + 1;
    end
    stall_q <= stall_en ? ~stall_q : 1'b0;
  end

  always @(negedge clk) begin
    if (peak_valid) pv_cnt <= pv_cnt + 1;
    if (fifo_rd_en && fifo_empty) viol <= viol + 1;
  end

  task automatic push(input logic last, input logic [11:0] idx, input logic [59:0] mag);
    mem[wp] = {last, idx, mag};
    wp++;
  endtask

  task automatic flush();
    @(negedge clk) flush_req = 1'b1;
    @(negedge clk) flush_req = 1'b0;
  endtask

  // Reference: walk the frame word by word, keep the first strictly-largest eligible bin.
  task automatic model(input int s, output logic [85:0] exp_v, output int exp_len);
    logic [11:0] bi = '0;
    logic [59:0] bm = '0;
    logic        err = 1'b0;
    int          c = 0;
    for (int i = s; i < wp; i++) begin
      c++;
      if (int'(mem[i][71:60]) >= SKIP && mem[i][59:0] > bm) begin
        bm = mem[i][59:0];
        bi = mem[i][71:60];
      end
      if (mem[i][72]) break;
      if (c == MAXL) begin
        err = 1'b1;
        break;
      end
    end
    exp_len = c;
    exp_v = {bi, bm, 13'(c), err};
  endtask

  task automatic wait_peak(input int budget, output bit ok, output logic [85:0] got);
    ok = 1'b0;
    got = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (peak_valid) begin
        ok = 1'b1;
        got = {peak_index, peak_mag, frame_len, frame_err};
        break;
      end
    end
  endtask

  task automatic run_frame(input int budget, output bit ok, output logic [85:0] got,
                           output int pv_delta, output int reads);
    int rp0 = rp;
    int pv0 = pv_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_peak(budget, ok, got);
    repeat (3) @(negedge clk);
    pv_delta = pv_cnt - pv0;
    reads = rp - rp0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", peak_valid); end
    checks++;
    if ({peak_index, peak_mag, frame_len, frame_err} !== 86'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {peak_index, peak_mag, frame_len, frame_err});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released: busy=%b peak_valid=%b", busy, peak_valid);
  endtask

  task automatic test_frame8(input bit stall);
    logic [59:0] m [8] = '{60'd900, 60'd5, 60'd7, 60'd30, 60'd12, 60'd30, 60'd1, 60'd2};
    logic [85:0] got, expv;
    bit ok; int pvd, rd, el;
    int s = wp;
    int v0 = viol;
    for (int i = 0; i < 8; i++) push(i == 7, 12'(i), m[i]);
    model(s, expv, el);
    stall_en = stall;
    run_frame(100, ok, got, pvd, rd);
    stall_en = 1'b0;
    $display("frame8 stall=%0d got=%h exp=%h reads=%0d", stall, got, expv, rd);
    checks++; if (!ok) begin fails++; $display("FAIL frame8_timeout: got no peak_valid expected one"); end
    checks++; if (got !== {12'd3, 60'd30, 13'd8, 1'b0}) begin fails++; $display("FAIL frame8_result: got %h expected %h", got, {12'd3, 60'd30, 13'd8, 1'b0}); end
    checks++; if (got !== expv) begin fails++; $display("FAIL frame8_model: got %h expected %h", got, expv); end
    checks++; if (pvd != 1) begin fails++; $display("FAIL frame8_pulses: got %0d expected 1", pvd); end
    checks++; if (rd != 8) begin fails++; $display("FAIL frame8_reads: got %0d expected 8", rd); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL frame8_busy: got %b expected 0", busy); end
    checks++; if (viol != v0) begin fails++; $display("FAIL frame8_rd_while_empty: got %0d expected %0d", viol, v0); end
  endtask

  task automatic test_two_words();
    logic [85:0] got;
    bit ok; int pvd, rd;
    push(1'b0, 12'd0, 60'd77);
    push(1'b1, 12'd1, 60'd99);
    run_frame(50, ok, got, pvd, rd);
    $display("two_words got=%h reads=%0d", got, rd);
    checks++; if (!ok || got !== {12'd0, 60'd0, 13'd2, 1'b0}) begin fails++; $display("FAIL two_words: got %h expected %h", got, {12'd0, 60'd0, 13'd2, 1'b0}); end
  endtask

  task automatic test_max_len();
    logic [85:0] got, expv;
    bit ok; int pvd, rd, el;
    int s = wp;
    for (int i = 0; i < MAXL; i++)
      push(1'b0, 12'(i), (i == 4000) ? 60'hFFF_FFFF_FFFF_FFFF : {28'd0, 32'($urandom)});
    push(1'b1, 12'd0, 60'd1);
    model(s, expv, el);
    run_frame(2 * MAXL + 50, ok, got, pvd, rd);
    $display("max_len got=%h exp=%h reads=%0d", got, expv, rd);
    checks++; if (!ok || got !== {12'd4000, 60'hFFF_FFFF_FFFF_FFFF, 13'd4096, 1'b1}) begin
      fails++; $display("FAIL max_len_result: got %h expected %h", got, {12'd4000, 60'hFFF_FFFF_FFFF_FFFF, 13'd4096, 1'b1});
    end
    checks++; if (got !== expv) begin fails++; $display("FAIL max_len_model: got %h expected %h", got, expv); end
    checks++; if (rd != MAXL) begin fails++; $display("FAIL max_len_reads: got %0d expected %0d", rd, MAXL); end
    flush();
  endtask

  task automatic test_back_to_back();
    logic [85:0] got, expa, expb;
    bit ok; int pvd, rd, la, lb;
    int sa = wp;
    int sb;
    push(1'b0, 12'd0, 60'd500); push(1'b0, 12'd2, 60'd40); push(1'b0, 12'd3, 60'd41);
    push(1'b0, 12'd4, 60'd41); push(1'b1, 12'd5, 60'd3);
    sb = wp;
    push(1'b0, 12'd0, 60'd9); push(1'b0, 12'd2, 60'd8); push(1'b0, 12'd3, 60'd70);
    push(1'b0, 12'd4, 60'd69); push(1'b0, 12'd5, 60'd70); push(1'b1, 12'd6, 60'd1);
    model(sa, expa, la);
    run_frame(60, ok, got, pvd, rd);
    $display("b2b frameA got=%h exp=%h reads=%0d", got, expa, rd);
    checks++; if (!ok || got !== expa) begin fails++; $display("FAIL b2b_a_result: got %h expected %h", got, expa); end
    checks++; if (rp != sb) begin fails++; $display("FAIL b2b_a_overread: got rp %0d expected %0d", rp, sb); end
    model(sb, expb, lb);
    run_frame(60, ok, got, pvd, rd);
    $display("b2b frameB got=%h exp=%h reads=%0d", got, expb, rd);
    checks++; if (!ok || got !== expb || rd != lb) begin fails++; $display("FAIL b2b_b_result: got %h/%0d expected %h/%0d", got, rd, expb, lb); end
  endtask

  task automatic test_busy_start();
    logic [85:0] got, expv;
    bit ok; int el;
    int s = wp;
    logic [12:0] fl0;
    push(1'b0, 12'd2, 60'd50); push(1'b0, 12'd3, 60'd60); push(1'b0, 12'd4, 60'd10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    fl0 = frame_len;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_start_busy: got %b expected 1", busy); end
    checks++; if (frame_len !== fl0) begin fails++; $display("FAIL busy_start_len: got %0d expected %0d", frame_len, fl0); end
    push(1'b0, 12'd5, 60'd20); push(1'b1, 12'd6, 60'd5);
    model(s, expv, el);
    wait_peak(50, ok, got);
    $display("busy_start got=%h exp=%h", got, expv);
    checks++; if (!ok || got !== expv) begin fails++; $display("FAIL busy_start_result: got %h expected %h", got, expv); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int rp0 = rp;
    int pv0;
    int rph;
    for (int i = 0; i < 8; i++) push(i == 7, 12'(i), 60'(100 + i));
    stall_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 50 && (rp - rp0) < 3; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset_mid at word %0d: busy=%b rd_en=%b valid=%b len=%0d", rp - rp0, busy, fifo_rd_en, peak_valid, frame_len);
    checks++; if (rp - rp0 != 3) begin fails++; $display("FAIL reset_mid_reach: got %0d expected 3", rp - rp0); end
    checks++; if ({busy, fifo_rd_en, peak_valid} !== 3'b000) begin fails++; $display("FAIL reset_mid_ctrl: got %b expected 000", {busy, fifo_rd_en, peak_valid}); end
    checks++; if ({peak_index, peak_mag, frame_len, frame_err} !== 86'd0) begin fails++; $display("FAIL reset_mid_outputs: got %h expected 0", {peak_index, peak_mag, frame_len, frame_err}); end
    stall_en = 1'b0;
    pv0 = pv_cnt;
    rph = rp;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (pv_cnt != pv0 || rp != rph) begin fails++; $display("FAIL reset_mid_after: got pv %0d rp %0d expected pv %0d rp %0d", pv_cnt, rp, pv0, rph); end
    flush();
  endtask

  task automatic test_random();
    logic [85:0] got, expv;
    bit ok; int pvd, rd, el, n, s;
    for (int f = 0; f < 20; f++) begin
      s = wp;
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        push(i == n - 1, 12'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) ? {28'd0, 32'($urandom)} : 60'($urandom_range(0, 9)));
      model(s, expv, el);
      stall_en = 1'($urandom_range(0, 1));
      run_frame(4 * n + 30, ok, got, pvd, rd);
      stall_en = 1'b0;
      $display("random %0d n=%0d got=%h exp=%h reads=%0d", f, n, got, expv, rd);
      checks++; if (!ok || got !== expv || rd != el || pvd != 1) begin
        fails++; $display("FAIL random_%0d: got %h reads %0d pulses %0d expected %h reads %0d pulses 1", f, got, rd, pvd, expv, el);
      end
    end
    checks++; if (viol != 0) begin fails++; $display("FAIL rd_while_empty_total: got %0d expected 0", viol); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_frame8(1'b0);
    test_frame8(1'b1);
    test_two_words();
    test_back_to_back();
    test_busy_start();
    test_reset_midframe();
    test_max_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 The block SHALL have parameter SKIP_BINS, default 2: number of lowest-index bins (DC region) excluded from the peak comparison.
REQ-002 The block SHALL have parameter MAX_LEN, default 4096: maximum words per frame before the frame is forcibly terminated.
REQ-003 The block SHALL have port clk, input, 1: single system clock for all logic.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle pulse that arms the search for one frame.
REQ-006 The block SHALL have port busy, output, 1: high from accepted start until the result pulse.
REQ-007 The block SHALL have port fifo_rd_en, output, 1: read enable to the 73-bit modulus FIFO.
REQ-008 The block SHALL have port fifo_rd_data, input, 73: FIFO word; [72] last-of-frame, [71:60] bin index, [59:0] unsigned squared modulus.
REQ-009 The block SHALL have port fifo_empty, input, 1: FIFO empty flag.
REQ-010 The block SHALL have port peak_valid, output, 1: one-cycle result strobe.
REQ-011 The block SHALL have port peak_index, output, 12: bin index of the maximum.
REQ-012 The block SHALL have port peak_mag, output, 60: modulus of the maximum.
REQ-013 The block SHALL have port frame_len, output, 13: number of words consumed in the frame.
REQ-014 The block SHALL have port frame_err, output, 1: valid with peak_valid; high when the frame ended on MAX_LEN rather than on the last flag.

Function
REQ-015 The block SHALL implement states IDLE, READ and DONE.
REQ-016 In IDLE, start=1 SHALL clear the accumulators (best_mag=0, best_idx=0, count=0), set busy=1 and enter READ on the next edge.
REQ-017 A start pulse while busy=1 SHALL be ignored.
REQ-018 In READ, fifo_rd_en SHALL equal !fifo_empty and SHALL be combinationally forced low in IDLE and DONE.
REQ-019 fifo_rd_data SHALL be treated as valid in the cycle after fifo_rd_en=1 (one-cycle read latency, no output register); the block SHALL register a data-valid flag delayed one cycle from fifo_rd_en.
REQ-020 For each valid word, count SHALL increment by 1; count SHALL saturate at MAX_LEN.
REQ-021 For a valid word whose index >= SKIP_BINS and whose modulus > best_mag (strictly greater), best_mag and best_idx SHALL be updated; ties SHALL keep the earlier (lower-arrival) bin.
REQ-022 When a valid word has [72]=1, or count reaches MAX_LEN, the FSM SHALL enter DONE, and fifo_rd_en SHALL be deasserted in that same cycle so that no word of the next frame is read.
REQ-023 The word that was read in the cycle the terminating word arrived SHALL NOT occur, because fifo_rd_en SHALL be gated off whenever a data-valid read is outstanding in the final position; reads SHALL be issued at most every cycle and the termination check SHALL use the current word, not the next one.
REQ-024 In DONE, the block SHALL assert peak_valid for exactly one cycle, present peak_index, peak_mag, frame_len=count and frame_err, then return to IDLE with busy=0 on the following edge.
REQ-025 peak_index, peak_mag, frame_len and frame_err SHALL hold their values until the next peak_valid.
REQ-026 If no word is eligible (all indices < SKIP_BINS, or all moduli 0), the block SHALL report peak_index=0 and peak_mag=0.
REQ-027 A stall (fifo_empty=1 mid-frame) SHALL pause reading without a timeout; the state SHALL remain READ.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, busy=0, fifo_rd_en=0, peak_valid=0, peak_index=0, peak_mag=0, frame_len=0, frame_err=0, and clear the data-valid flag and all accumulators.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no peak_valid; remaining FIFO words SHALL be left in the FIFO.

Verification
REQ-030 Frame of 8 words with indices 0..7, moduli {900,5,7,30,12,30,1,2}, last on index 7 -> single peak_valid, peak_index=3, peak_mag=30, frame_len=8, frame_err=0 (DC 900 skipped, tie keeps 3).
REQ-031 Same frame with fifo_empty toggling every other cycle -> identical result; fifo_rd_en never high while fifo_empty=1.
REQ-032 Frame of 4096 words with no last flag, maximum 0xFFFFFFFFFFFFFFF at index 4000 -> peak_index=4000, peak_mag=0xFFFFFFFFFFFFFFF, frame_len=4096, frame_err=1, and no 4097th read.
REQ-033 Two back-to-back frames in the FIFO with one start -> only the first frame is consumed; the first word of the second frame remains unread; a second start returns the second frame's peak.
REQ-034 rst_n pulsed low at word 3 of an 8-word frame -> all outputs 0 immediately, no peak_valid; start pulse during busy ignored (busy and frame_len unaffected).
REQ-035 Frame of 2 words, indices 0 and 1, last on index 1 -> peak_index=0, peak_mag=0, frame_len=2, frame_err=0.
